// File: rtl/dip_scan_pkg.sv
// Shared types and sizing for the DIP/switch scan controller.
package dip_scan_pkg;

  localparam int DIP_W      = 16;
  localparam int SW_W       = 5;
  localparam int FRAME_BITS = DIP_W + SW_W;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int MATCH_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    CHECK = 2'd3
  } scan_state_e;

  typedef logic [FRAME_BITS-1:0] frame_t;

  function automatic logic [MATCH_W-1:0] sat_inc(input logic [MATCH_W-1:0] value,
                                                 input logic [MATCH_W-1:0] limit);
    return (value >= limit) ? limit : value + MATCH_W'(1);
  endfunction

endpackage

// File: rtl/dip_scan_controller_if.sv
// Board-pin and host-facing signals of the scan controller.
interface dip_scan_controller_if;
  import dip_scan_pkg::*;

  logic             i_Data;
  logic             i_ScanReq;
  logic             i_Continuous;
  logic             o_SerClk;
  logic             o_Latch_n;
  logic [DIP_W-1:0] o_DIP16;
  logic [SW_W-1:0]  o_Switch5;
  logic             o_Changed;
  logic             o_Busy;
  logic             o_Stable;

  modport master (
    input  i_Data, i_ScanReq, i_Continuous,
    output o_SerClk, o_Latch_n, o_DIP16, o_Switch5, o_Changed, o_Busy, o_Stable
  );

  modport slave (
    output i_Data, i_ScanReq, i_Continuous,
    input  o_SerClk, o_Latch_n, o_DIP16, o_Switch5, o_Changed, o_Busy, o_Stable
  );

endinterface

// File: rtl/dip_scan_clkgen.sv
// Bit-period phase counter: serial clock level, data sample strobe and period-end strobe.
module dip_scan_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic shift,
  output logic ser_clk,
  output logic sample,
  output logic period_end
);

  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] phase_r;
  logic [PH_W-1:0] phase_s;
  logic            ser_clk_r;

  // Phase advance; held at zero while disabled so every state starts a fresh period
  always_comb begin
    phase_s = '0;
    if (en && (phase_r != PH_LAST)) begin
      phase_s = phase_r + PH_W'(1);
    end else begin
      phase_s = '0;
    end
  end

  // Phase register and serial clock: high exactly while phase is in the second half
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r   <= '0;
      ser_clk_r <= 1'b0;
    end else begin
      phase_r   <= phase_s;
      ser_clk_r <= shift && (phase_r >= PH_SAMPLE) && (phase_r != PH_LAST);
    end
  end

  assign ser_clk    = ser_clk_r;
  assign sample     = shift && (phase_r == PH_SAMPLE);
  assign period_end = en && (phase_r == PH_LAST);

endmodule

// File: rtl/dip_scan_controller.sv
// Serial DIP/switch chain sequencer with frame-to-frame debounce and change strobe.
module dip_scan_controller
  import dip_scan_pkg::*;
#(
  parameter int CLK_DIV         = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input logic                  i_CLK,
  input logic                  i_RESET,
  dip_scan_controller_if.master bus
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [MATCH_W-1:0]   DEB_LIM  = MATCH_W'(DEBOUNCE_FRAMES);

  scan_state_e          state_r, state_s;
  logic [BIT_CNT_W-1:0] bit_cnt_r;
  frame_t               shift_r, prev_r;
  logic [MATCH_W-1:0]   match_r, match_s;
  logic [DIP_W-1:0]     dip_r;
  logic [SW_W-1:0]      sw_r;
  logic                 changed_r, stable_r, latch_n_r, busy_r;
  logic                 ser_clk_s, sample_s, period_end_s;
  logic                 deb_met_s, load_s;

  dip_scan_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk        (i_CLK),
    .rst        (i_RESET),
    .en         ((state_r == LATCH) || (state_r == SHIFT)),
    .shift      (state_r == SHIFT),
    .ser_clk    (ser_clk_s),
    .sample     (sample_s),
    .period_end (period_end_s)
  );

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = (bus.i_ScanReq || bus.i_Continuous) ? LATCH : IDLE;
      LATCH:   state_s = period_end_s ? SHIFT : LATCH;
      SHIFT:   state_s = (period_end_s && (bit_cnt_r == BIT_LAST)) ? CHECK : SHIFT;
      CHECK:   state_s = bus.i_Continuous ? LATCH : IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Debounce decision for the frame just received; a differing frame restarts the run at one
  always_comb begin
    match_s   = (shift_r == prev_r) ? sat_inc(match_r, DEB_LIM) : MATCH_W'(1);
    deb_met_s = (match_s == DEB_LIM);
    load_s    = deb_met_s && (shift_r != {dip_r, sw_r});
  end

  // FSM, bit counter and deserialiser; strobes are registered from the next state
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_r   <= IDLE;
      latch_n_r <= 1'b1;
      busy_r    <= 1'b0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
    end else begin
      state_r   <= state_s;
      latch_n_r <= (state_s != LATCH);
      busy_r    <= (state_s != IDLE);
      if (state_r != SHIFT) begin
        bit_cnt_r <= '0;
      end else if (period_end_s) begin
        bit_cnt_r <= (bit_cnt_r == BIT_LAST) ? '0 : bit_cnt_r + BIT_CNT_W'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (sample_s) begin
        shift_r <= {shift_r[FRAME_BITS-2:0], bus.i_Data};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  // Debounce history and parallel outputs, updated only in CHECK
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      prev_r    <= '0;
      match_r   <= '0;
      dip_r     <= '0;
      sw_r      <= '0;
      changed_r <= 1'b0;
      stable_r  <= 1'b0;
    end else begin
      changed_r <= 1'b0;
      if (state_r == CHECK) begin
        prev_r  <= shift_r;
        match_r <= match_s;
        if (deb_met_s) begin
          stable_r <= 1'b1;
        end
        if (load_s) begin
          dip_r     <= shift_r[FRAME_BITS-1:SW_W];
          sw_r      <= shift_r[SW_W-1:0];
          changed_r <= 1'b1;
        end
      end
    end
  end

  assign bus.o_SerClk  = ser_clk_s;
  assign bus.o_Latch_n = latch_n_r;
  assign bus.o_DIP16   = dip_r;
  assign bus.o_Switch5 = sw_r;
  assign bus.o_Changed = changed_r;
  assign bus.o_Busy    = busy_r;
  assign bus.o_Stable  = stable_r;

endmodule

// File: tb/tb_dip_scan_controller.sv
// Self-checking bench: shift-register chain model plus frame-history debounce reference.
module tb_dip_scan_controller;
  import dip_scan_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int DEB       = 3;
  localparam int FRAME_CYC = 2 * CLK_DIV * (1 + FRAME_BITS) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dip_scan_controller_if bus ();

  dip_scan_controller #(.CLK_DIV(CLK_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .bus     (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          chg_count = 0;
  logic [20:0] stim [64];
  int          chain_idx = 0;
  logic [20:0] chain = '0;
  logic        prev_latch = 1'b1;
  logic        prev_ser = 1'b0;
  logic        prev_chg = 1'b0;

  logic [20:0] hist [$];
  logic [20:0] exp_val;
  bit          exp_stable;

  // Parallel-in/serial-out chain: loads on latch, shifts on each serial clock rise
  initial begin
    bus.i_Data = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.o_Latch_n && prev_latch) begin
        chain = (chain_idx < 64) ? stim[chain_idx] : 21'h0;
        chain_idx++;
      end else if (bus.o_SerClk && !prev_ser) begin
        chain = {chain[19:0], 1'b0};
      end
      prev_latch = bus.o_Latch_n;
      prev_ser   = bus.o_SerClk;
      bus.i_Data = chain[20];
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_Changed) begin
        chg_count++;
        n_assert++;
        if (prev_chg) begin
          n_fail++;
          $display("FAIL changed_pulse_width: high two cycles in a row at %0t", $time);
        end
      end
      prev_chg = bus.o_Changed;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic model_reset();
    hist.delete();
    exp_val    = 21'h0;
    exp_stable = 1'b0;
  endtask

  // Outputs follow the newest value seen in DEB identical consecutive frames
  task automatic model_frame(input logic [20:0] v, output bit chg);
    bit all_eq;
    chg = 1'b0;
    hist.push_back(v);
    if (hist.size() >= DEB) begin
      all_eq = 1'b1;
      for (int j = hist.size() - DEB; j < hist.size(); j++)
        if (hist[j] != v) all_eq = 1'b0;
      if (all_eq) begin
        exp_stable = 1'b1;
        if (v != exp_val) begin
          exp_val = v;
          chg     = 1'b1;
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_ScanReq = 1'b0;
    bus.i_Continuous = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic run_frames(input int n, input bit cont);
    bit chg;
    bit ok;
    chain_idx = 0;
    bus.i_Continuous = cont;
    for (int i = 0; i < n; i++) begin
      if (!cont) begin
        bus.i_ScanReq = 1'b1;
        @(negedge clk);
        bus.i_ScanReq = 1'b0;
      end
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (!bus.o_Latch_n) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      n_assert++;
      if (!ok) begin
        n_fail++;
        $display("FAIL frame_start: frame %0d never latched (got latch_n=%b, need 0)", i, bus.o_Latch_n);
        bus.i_Continuous = 1'b0;
        return;
      end
      if (i == n - 1) bus.i_Continuous = 1'b0;
      repeat (FRAME_CYC) @(negedge clk);
      model_frame(stim[i], chg);
      n_assert += 4;
      if (bus.o_Changed !== chg) begin
        n_fail++;
        $display("FAIL frame_changed: frame %0d got %b need %b", i, bus.o_Changed, chg);
      end
      if ({bus.o_DIP16, bus.o_Switch5} !== exp_val) begin
        n_fail++;
        $display("FAIL frame_value: frame %0d got %h need %h", i, {bus.o_DIP16, bus.o_Switch5}, exp_val);
      end
      if (bus.o_Stable !== exp_stable) begin
        n_fail++;
        $display("FAIL frame_stable: frame %0d got %b need %b", i, bus.o_Stable, exp_stable);
      end
      if (bus.o_Busy !== (cont && (i < n - 1))) begin
        n_fail++;
        $display("FAIL frame_busy: frame %0d got %b need %b", i, bus.o_Busy, cont && (i < n - 1));
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bus.i_ScanReq = 1'b0;
    bus.i_Continuous = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_assert += 2;
    if ({bus.o_SerClk, bus.o_Latch_n, bus.o_Busy, bus.o_Stable, bus.o_Changed} !== 5'b01000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b need 01000",
               {bus.o_SerClk, bus.o_Latch_n, bus.o_Busy, bus.o_Stable, bus.o_Changed});
    end
    if ({bus.o_DIP16, bus.o_Switch5} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_value: got %h need 0", {bus.o_DIP16, bus.o_Switch5});
    end
    rst = 1'b0;
    model_reset();
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus.o_SerClk || !bus.o_Latch_n || bus.o_Busy || bus.o_Changed) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: got %0d active cycles need 0", bad);
    end
  endtask

  task automatic test_all_zero();
    int c0;
    for (int i = 0; i < 4; i++) stim[i] = 21'h0;
    c0 = chg_count;
    run_frames(4, 1'b1);
    n_assert += 2;
    if (bus.o_Stable !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_stable: got %b need 1", bus.o_Stable);
    end
    if (chg_count - c0 != 0) begin
      n_fail++;
      $display("FAIL zero_changed: got %0d pulses need 0", chg_count - c0);
    end
  endtask

  task automatic test_toggle();
    apply_reset();
    for (int i = 0; i < 6; i++) stim[i] = (i % 2 == 0) ? {16'h0001, 5'h00} : {16'h0002, 5'h00};
    run_frames(6, 1'b1);
    n_assert++;
    if ({bus.o_Stable, bus.o_DIP16, bus.o_Switch5} !== 22'h0) begin
      n_fail++;
      $display("FAIL toggle_hold: got %h need 0", {bus.o_Stable, bus.o_DIP16, bus.o_Switch5});
    end
  endtask

  task automatic test_single_shot();
    int  lc, rises, bc, extra;
    bit  done, chg;
    logic sp;
    apply_reset();
    stim[0] = 21'($urandom);
    chain_idx = 0;
    bus.i_ScanReq = 1'b1;
    @(negedge clk);
    bus.i_ScanReq = 1'b0;
    lc = 0; rises = 0; bc = 0; done = 1'b0; sp = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.i_ScanReq = (c == 60);
      if (!bus.o_Latch_n) lc++;
      if (bus.o_SerClk && !sp) rises++;
      sp = bus.o_SerClk;
      if (bus.o_Busy) bc++;
      else begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.i_ScanReq = 1'b0;
    model_frame(stim[0], chg);
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_Busy) extra++;
    end
    n_assert += 5;
    if (!done) begin
      n_fail++;
      $display("FAIL single_done: busy never dropped");
    end
    if (bc != FRAME_CYC) begin
      n_fail++;
      $display("FAIL single_busy: got %0d cycles need %0d", bc, FRAME_CYC);
    end
    if (lc != 2 * CLK_DIV) begin
      n_fail++;
      $display("FAIL single_latch: got %0d cycles need %0d", lc, 2 * CLK_DIV);
    end
    if (rises != FRAME_BITS) begin
      n_fail++;
      $display("FAIL single_serclk: got %0d rises need %0d", rises, FRAME_BITS);
    end
    if (extra != 0) begin
      n_fail++;
      $display("FAIL single_ignored_req: got %0d busy cycles after frame need 0", extra);
    end
  endtask

  task automatic test_debounce_lock();
    int c0;
    apply_reset();
    for (int i = 0; i < 13; i++) stim[i] = {16'hA5C3, 5'h15};
    c0 = chg_count;
    run_frames(13, 1'b1);
    n_assert += 3;
    if (chg_count - c0 != 1) begin
      n_fail++;
      $display("FAIL lock_pulses: got %0d need 1", chg_count - c0);
    end
    if (bus.o_DIP16 !== 16'hA5C3) begin
      n_fail++;
      $display("FAIL lock_dip: got %h need a5c3", bus.o_DIP16);
    end
    if (bus.o_Switch5 !== 5'h15) begin
      n_fail++;
      $display("FAIL lock_sw: got %h need 15", bus.o_Switch5);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [20:0] v;
    int c0;
    stim[0] = 21'($urandom);
    chain_idx = 0;
    bus.i_ScanReq = 1'b1;
    @(negedge clk);
    bus.i_ScanReq = 1'b0;
    repeat (2 * CLK_DIV + 10 * 2 * CLK_DIV + 2) @(negedge clk);
    n_assert++;
    if (bus.o_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midshift_busy: got %b need 1", bus.o_Busy);
    end
    rst = 1'b1;
    bus.i_Continuous = 1'b1;
    @(negedge clk);
    n_assert += 2;
    if ({bus.o_SerClk, bus.o_Latch_n, bus.o_Busy, bus.o_Stable, bus.o_Changed} !== 5'b01000) begin
      n_fail++;
      $display("FAIL midshift_ctrl: got %b need 01000",
               {bus.o_SerClk, bus.o_Latch_n, bus.o_Busy, bus.o_Stable, bus.o_Changed});
    end
    if ({bus.o_DIP16, bus.o_Switch5} !== 21'h0) begin
      n_fail++;
      $display("FAIL midshift_value: got %h need 0", {bus.o_DIP16, bus.o_Switch5});
    end
    rst = 1'b0;
    model_reset();
    v = 21'($urandom) | 21'h00100;
    for (int i = 0; i < 4; i++) stim[i] = v;
    c0 = chg_count;
    run_frames(4, 1'b1);
    n_assert++;
    if (chg_count - c0 != 1) begin
      n_fail++;
      $display("FAIL restart_pulses: got %0d need 1", chg_count - c0);
    end
  endtask

  task automatic test_random();
    logic [20:0] pool [3];
    int n, run;
    logic [20:0] v;
    apply_reset();
    for (int k = 0; k < 3; k++) pool[k] = 21'($urandom);
    n = 0;
    while (n < 36) begin
      v = pool[$urandom_range(0, 2)];
      run = $urandom_range(1, 4);
      for (int r = 0; r < run && n < 36; r++) begin
        stim[n] = v;
        n++;
      end
    end
    run_frames(24, 1'b1);
    for (int i = 0; i < 12; i++) stim[i] = stim[24 + i];
    run_frames(12, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) stim[i] = 21'h0;
    bus.i_ScanReq = 1'b0;
    bus.i_Continuous = 1'b0;
    model_reset();
    test_reset();
    test_all_zero();
    test_toggle();
    test_single_shot();
    test_debounce_lock();
    test_reset_mid_shift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
